// File: rtl/alu_pipe_if.sv
// Issue-side and result-side valid/ready channels of the pipelined ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with tags; result valid after the second edge.
// Backpressure: S2 holds on !out_ready, S1 holds behind it, in_ready drops when both are full.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    alu_pipe_if.slave bus,
    output logic      busy
);
    localparam int SH_W = $clog2(WIDTH);

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } op_t;

    op_t              s1_q;
    logic             s1_vld_q, s1_vld_d;
    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [TAG_W-1:0] tag_q;
    logic             s2_adv, s1_free, accept, s2_load, cmp;
    logic [SH_W-1:0]  shamt;

    assign s2_adv       = !s2_vld_q || bus.out_ready;
    assign s1_free      = !s1_vld_q || s2_adv;
    assign bus.in_ready = s1_free && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign s2_load      = s1_vld_q && s2_adv && !flush;

    assign bus.out_valid  = s2_vld_q;
    assign bus.out_result = res_q;
    assign bus.out_tag    = tag_q;
    assign busy           = s1_vld_q || s2_vld_q;

    assign shamt = s1_q.b[SH_W-1:0];

    always_comb begin
        cmp   = 1'b0;
        res_d = '0;
        case (s1_q.op)
            4'd0:  res_d = s1_q.a + s1_q.b;
            4'd1:  res_d = s1_q.a & s1_q.b;
            4'd2:  res_d = s1_q.a | s1_q.b;
            4'd3:  res_d = s1_q.a << shamt;
            4'd4:  res_d = s1_q.a >> shamt;
            4'd7:  res_d = $unsigned($signed(s1_q.a) >>> shamt);
            4'd8:  res_d = s1_q.a - s1_q.b;
            4'd9:  res_d = s1_q.a ^ s1_q.b;
            4'd5:  cmp = $signed(s1_q.a) < $signed(s1_q.b);
            4'd6:  cmp = s1_q.a < s1_q.b;
            4'd10: cmp = s1_q.a == s1_q.b;
            4'd11: cmp = $signed(s1_q.a) >= $signed(s1_q.b);
            4'd12: cmp = s1_q.a != s1_q.b;
            4'd13: cmp = s1_q.a >= s1_q.b;
            default: res_d = '0;
        endcase
        if (s1_q.op inside {4'd5, 4'd6, 4'd10, 4'd11, 4'd12, 4'd13}) begin
            res_d = {{(WIDTH-1){1'b0}}, cmp};
        end
    end

    // Flush kills both valid bits; payload registers may keep stale data.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            if (s2_adv) s2_vld_d = s1_vld_q;
            if (s1_free) s1_vld_d = bus.in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s1_q     <= '0;
            res_q    <= '0;
            tag_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            if (accept) begin
                s1_q <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
            end
            if (s2_load) begin
                res_q <= res_d;
                tag_q <= s1_q.tag;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: queue-based reference model plus literal checks.
module tb_alu_pipe;
    logic clk, rst_n, flush, busy;
    logic flush8, busy8;

    alu_pipe_if #(.WIDTH(32), .TAG_W(3)) bus ();
    alu_pipe_if #(.WIDTH(8), .TAG_W(3))  bus8 ();

    alu_pipe #(.WIDTH(32), .TAG_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .busy(busy)
    );
    alu_pipe #(.WIDTH(8), .TAG_W(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8), .bus(bus8), .busy(busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a & b;
            4'd2:  return a | b;
            4'd3:  return a << sh;
            4'd4:  return a >> sh;
            4'd7:  return 32'(sa >>> sh);
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return a - b;
            4'd9:  return a ^ b;
            4'd10: return (a == b) ? 32'd1 : 32'd0;
            4'd11: return (sa >= sb) ? 32'd1 : 32'd0;
            4'd12: return (a != b) ? 32'd1 : 32'd0;
            4'd13: return (a >= b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] r;
        logic [2:0]  t;
        int          e;
    } exp_t;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  t;
    } got_t;

    exp_t mq[$];
    got_t got[$];
    int   edge_cnt = 0;

    // Model: every accepted op is owed exactly once, in order; flush/reset forgive all.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            edge_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                got.push_back('{r: bus.out_result, t: bus.out_tag});
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if (flush) begin
                mq.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                mq.push_back('{r: model(bus.in_op, bus.in_a, bus.in_b), t: bus.in_tag, e: edge_cnt});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_out_valid", bus.out_valid,
                (mq.size() > 0 && mq[0].e <= edge_cnt - 1) ? 1'b1 : 1'b0);
            chk("model_busy", busy, (mq.size() > 0) ? 1'b1 : 1'b0);
            if (bus.out_valid && mq.size() > 0) begin
                chk("model_result", bus.out_result, mq[0].r);
                chk("model_tag", bus.out_tag, mq[0].t);
            end
        end
    end

    task automatic wait_accept(output int cycles);
        bit ok;
        cycles = 0;
        ok     = 1'b0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #2;
            cycles++;
        end while (!ok && cycles < 50);
        if (!ok) chk("accept_timeout", ok, 1'b1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] tag, output int cycles);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        wait_accept(cycles);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int c = 0;
        while (got.size() < n && c < 100) begin
            @(posedge clk);
            #2;
            c++;
        end
        if (got.size() < n) chk("drain_timeout", got.size(), n);
    endtask

    task automatic pause(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int c1, c2;
        bit ok;
        rst_n = 1'b0;
        flush = 1'b0;
        flush8 = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
        bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_op = '0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_tag = '0;
        bus8.out_ready = 1'b1;

        chk("pin_add", model(4'd0, 32'd5, 32'd7), 32'd12);
        chk("pin_sra", model(4'd7, 32'h8000_0000, 32'd31), 32'hFFFF_FFFF);
        chk("pin_sltu", model(4'd6, 32'd1, 32'hFFFF_FFFF), 32'd1);

        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_tag", bus.out_tag, 3'd0);
        chk("rst_busy", busy, 1'b0);
        pause(2);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        pause(1);

        // Back-to-back ADD then SUB, latency and throughput.
        issue(4'd0, 32'd5, 32'd7, 3'd2, c1);
        issue(4'd8, 32'd3, 32'd5, 3'd4, c2);
        idle();
        chk("add_accept_cycles", c1, 1);
        chk("sub_accept_cycles", c2, 1);
        @(negedge clk);
        chk("add_valid", bus.out_valid, 1'b1);
        chk("add_result", bus.out_result, 32'd12);
        chk("add_tag", bus.out_tag, 3'd2);
        chk("add_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("sub_valid", bus.out_valid, 1'b1);
        chk("sub_result", bus.out_result, 32'hFFFF_FFFE);
        chk("sub_tag", bus.out_tag, 3'd4);
        @(negedge clk);
        chk("drained_valid", bus.out_valid, 1'b0);
        pause(1);

        // Signedness, shifts and the undefined opcode.
        vecs[0] = '{op: 4'd5,  a: 32'hFFFF_FFF0, b: 32'h10, r: 32'd1};
        vecs[1] = '{op: 4'd6,  a: 32'hFFFF_FFF0, b: 32'h10, r: 32'd0};
        vecs[2] = '{op: 4'd11, a: 32'hFFFF_FFF0, b: 32'h10, r: 32'd0};
        vecs[3] = '{op: 4'd13, a: 32'hFFFF_FFF0, b: 32'h10, r: 32'd1};
        vecs[4] = '{op: 4'd7,  a: 32'hFFFF_FFF0, b: 32'h24, r: 32'hFFFF_FFFF};
        vecs[5] = '{op: 4'd4,  a: 32'hFFFF_FFF0, b: 32'h24, r: 32'h0FFF_FFFF};
        vecs[6] = '{op: 4'd3,  a: 32'd1,         b: 32'h21, r: 32'd2};
        vecs[7] = '{op: 4'd15, a: 32'h1234,      b: 32'h5,  r: 32'd0};
        got.delete();
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, (i == 7) ? 3'd5 : 3'(i), c1);
        end
        idle();
        wait_got(8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            chk($sformatf("vec%0d_result", i), got[i].r, vecs[i].r);
            chk($sformatf("vec%0d_tag", i), got[i].t, (i == 7) ? 3'd5 : 3'(i));
        end

        // Backpressure: two accepts fill the pipe, third stalls.
        bus.out_ready = 1'b0;
        got.delete();
        issue(4'd0, 32'd1, 32'd10, 3'd1, c1);
        issue(4'd0, 32'd2, 32'd10, 3'd2, c2);
        bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.in_a = 32'd3; bus.in_b = 32'd10; bus.in_tag = 3'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_result", bus.out_result, 32'd11);
            chk("bp_tag", bus.out_tag, 3'd1);
            @(posedge clk);
            #2;
        end
        bus.out_ready = 1'b1;
        wait_accept(c1);
        idle();
        wait_got(3);
        pause(4);
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            chk($sformatf("bp%0d_tag", i), got[i].t, 3'(i + 1));
            chk($sformatf("bp%0d_result", i), got[i].r, 32'(11 + i));
        end

        // Flush with two ops in flight and a new op offered.
        bus.out_ready = 1'b0;
        issue(4'd0, 32'd4, 32'd0, 3'd4, c1);
        issue(4'd0, 32'd5, 32'd0, 3'd5, c2);
        bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.in_a = 32'd6; bus.in_b = 32'd0; bus.in_tag = 3'd6;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #2;
        flush = 1'b0;
        idle();
        got.delete();
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        issue(4'd0, 32'd20, 32'd22, 3'd3, c1);
        idle();
        wait_got(1);
        pause(4);
        chk("flush_after_count", got.size(), 1);
        if (got.size() > 0) begin
            chk("flush_after_result", got[0].r, 32'd42);
            chk("flush_after_tag", got[0].t, 3'd3);
        end

        // Asynchronous reset between clock edges.
        issue(4'd0, 32'd100, 32'd1, 3'd1, c1);
        issue(4'd0, 32'd200, 32'd2, 3'd2, c2);
        idle();
        #1;
        chk("pre_rst_result", bus.out_result, 32'd101);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_out_result", bus.out_result, 32'd0);
        chk("arst_out_tag", bus.out_tag, 3'd0);
        chk("arst_busy", busy, 1'b0);
        pause(2);
        rst_n = 1'b1;
        got.delete();
        issue(4'd0, 32'd1, 32'd1, 3'd7, c1);
        idle();
        wait_got(1);
        pause(4);
        chk("post_rst_count", got.size(), 1);
        if (got.size() > 0) begin
            chk("post_rst_result", got[0].r, 32'd2);
            chk("post_rst_tag", got[0].t, 3'd7);
        end

        // 8-bit instance wraps modulo 2^8.
        bus8.in_valid = 1'b1; bus8.in_op = 4'd0; bus8.in_a = 8'hFF; bus8.in_b = 8'h01; bus8.in_tag = 3'd3;
        @(negedge clk);
        ok = bus8.in_ready;
        chk("w8_in_ready", ok, 1'b1);
        @(posedge clk);
        #2;
        bus8.in_valid = 1'b0;
        c1 = 0;
        while (!bus8.out_valid && c1 < 20) begin
            @(negedge clk);
            c1++;
        end
        chk("w8_out_valid", bus8.out_valid, 1'b1);
        chk("w8_result", bus8.out_result, 8'h00);
        chk("w8_tag", bus8.out_tag, 3'd3);
        pause(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined integer ALU; successor to the single-op execution unit.
- Sits between the issue stage and the common data bus.
- Adds a valid/ready handshake on both sides, backpressure, a destination tag carried with each operation, flush for mispredict recovery, and configurable data and tag width.
- Keeps the existing 4-bit opcode map unchanged.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, 8..64.
- TAG_W, 3, destination tag width.
- Local SH_W = log2(WIDTH), shift-amount width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight ops.
- in_valid  input  1  issue side has an op.
- in_ready  output  1  ALU accepts the op this cycle.
- in_op  input  4  opcode.
- in_a  input  WIDTH  operand 1.
- in_b  input  WIDTH  operand 2.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result this cycle.
- out_result  output  WIDTH  result.
- out_tag  output  TAG_W  tag of result.
- busy  output  1  any stage holds a valid op.

Behaviour:
- Opcodes:
  - 0 ADD, 1 AND, 2 OR.
  - 3 SLL, 4 SRL (logical), 7 SRA (arithmetic, sign-filled); all use in_b[SH_W-1:0].
  - 5 SLT (signed), 6 SLTU (unsigned).
  - 8 SUB, 9 XOR.
  - 10 EQ, 11 GE (signed), 12 NE, 13 GEU (unsigned).
  - Compare ops return 1 or 0, zero-extended to WIDTH.
  - Opcodes 14 and 15 return 0 and still produce a valid output with their tag.
- Arithmetic wraps modulo 2^WIDTH; no flags.
- Stage S1 registers op, a, b, tag and s1_valid.
- Stage S2 registers the computed result, tag and s2_valid. S2 drives the outputs directly from flops; out_result and out_tag never come from combinational logic.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - in_ready = (!s1_valid | s2_adv) & !flush.
  - Accept when in_valid & in_ready. Transfer out when out_valid & out_ready.
- Latency: an op accepted at edge N is presented at out_valid after edge N+1. With out_ready held high, results appear on consecutive cycles, giving throughput of 1 op/cycle.
- Backpressure: while out_valid & !out_ready, S2 holds result and tag stable. S1 holds if valid. in_ready drops once both stages are full.
- Simultaneous transfer: out transfer and S1 to S2 move in the same cycle with no bubble.
- A value may be held in out_result while out_valid=0; consumers must qualify with out_valid.
- flush:
  - At the rising edge, s1_valid and s2_valid clear. Data registers may retain stale values.
  - in_ready=0 during flush, so a same-cycle in_valid is not accepted.
  - A same-cycle out transfer still completes from the consumer's view.
  - out_valid is 0 in the cycle after flush.
- busy = s1_valid | s2_valid.
- Reset (rst_n low, async):
  - s1_valid = s2_valid = 0.
  - out_result = 0, out_tag = 0.
  - in_ready = 1 once rst_n is high.
  - Reset mid-operation discards all in-flight ops with no partial output.
- Input ops/operands need not be held stable after acceptance.

Test Plan:
- WIDTH=32, out_ready=1. Issue ADD 5+7 tag 2, then SUB 3-5 tag 4 on consecutive cycles.
  -> out 12/tag2, then 0xFFFFFFFE/tag4 on consecutive cycles. in_ready stays 1.
- Signedness and shifts with a=0xFFFFFFF0, b=0x00000010:
  - SLT -> 1; SLTU -> 0; GE -> 0; GEU -> 1.
  - SRA by b=0x24 (shamt 4) -> 0xFFFFFFFF; SRL -> 0x0FFFFFFF.
  - SLL of 1 by 0x21 -> 2.
- Backpressure: out_ready=0 while issuing 3 ops (tags 1,2,3).
  - in_ready falls after 2 accepts; the third op stalls.
  - out_result/out_tag stay stable while stalled.
  - Raising out_ready drains tags 1,2,3 in order with no loss or duplication.
- Flush: pulse flush with 2 ops in flight and in_valid high.
  - Next cycle out_valid=0 and busy=0. The flush-cycle op never emerges.
  - Next op issued emerges normally.
- Reset: drop rst_n asynchronously mid-stream (between clock edges).
  - Outputs go to 0 and out_valid to 0 immediately.
  - After release, ADD 1+1 tag 7 -> 2/tag7.
- Opcode 15 with tag 5 -> out_valid with result 0, tag 5. Also repeat the ADD case at WIDTH=8: 0xFF+0x01 -> 0x00.
